// File: rtl/fir_pkg.sv
// fir_pkg: shared FSM state type and default sizing for the FIR controller.
package fir_pkg;
    localparam int DefTapCount  = 64;
    localparam int DefAddrWidth = 6;
    localparam int DefPipeDepth = 2;

    typedef enum logic [1:0] {IDLE, CALC, DRAIN, DONE} fir_state_t;
endpackage

// File: rtl/tap_counter.sv
// tap_counter: loadable up-counter with clear and enable, wrapping after Last.
module tap_counter #(
    parameter int Width = 6,
    parameter int Last  = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [Width-1:0] value,
    input  logic             en,
    output logic [Width-1:0] count,
    output logic             tc
);
    assign tc = count == Width'(Last);

    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (load) count <= value;
        else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/fir_controller.sv
// fir_controller: sequences one tap sweep plus pipeline drain per accepted sample.
module fir_controller
    import fir_pkg::*;
#(
    parameter int TapCount  = DefTapCount,
    parameter int AddrWidth = DefAddrWidth,
    parameter int PipeDepth = DefPipeDepth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din_valid,
    output logic                 ready,
    output logic                 shift,
    output logic                 flush,
    output logic [AddrWidth-1:0] address,
    output logic                 acc_en,
    output logic                 dout_valid
);
    localparam int DrainWidth = PipeDepth > 1 ? $clog2(PipeDepth) : 1;

    fir_state_t state, next;
    logic [DrainWidth-1:0] drain_cnt;
    logic addr_tc, drain_tc, accept, acc_next;

    // ready is low throughout reset, so it also gates accepts while rst=0
    assign accept = ready & din_valid;
    assign shift  = accept;
    assign flush  = accept;

    tap_counter #(.Width(AddrWidth), .Last(TapCount - 1)) u_addr (
        .clk(clk), .rst(rst), .clr(state != CALC), .load(1'b0), .value('0),
        .en(state == CALC), .count(address), .tc(addr_tc)
    );

    tap_counter #(.Width(DrainWidth), .Last(PipeDepth - 1)) u_drain (
        .clk(clk), .rst(rst), .clr(state != DRAIN), .load(1'b0), .value('0),
        .en(state == DRAIN), .count(drain_cnt), .tc(drain_tc)
    );

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = accept ? CALC : IDLE;
            CALC:    next = addr_tc ? DRAIN : CALC;
            DRAIN:   next = drain_tc ? DONE : DRAIN;
            default: next = IDLE;
        endcase
        // accumulation stays open for the first PipeDepth-1 drain cycles
        acc_next = next == CALC || (next == DRAIN &&
                   (state == CALC ? PipeDepth > 1 : 32'(drain_cnt) + 1 < PipeDepth - 1));
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state      <= IDLE;
            ready      <= 1'b0;
            acc_en     <= 1'b0;
            dout_valid <= 1'b0;
        end else begin
            state      <= next;
            ready      <= next == IDLE;
            acc_en     <= acc_next;
            dout_valid <= next == DONE;
        end
endmodule

// File: tb/tb_fir_controller.sv
// tb_fir_controller: timeline reference model plus a behavioural datapath for end-to-end sums.
module tb_fir_controller;
    logic clk = 0, rst = 0, din_valid = 0;
    logic ready, shift, flush, acc_en, dout_valid;
    logic [5:0] address;
    logic [15:0] din = 0;

    fir_controller dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .ready(ready), .shift(shift),
        .flush(flush), .address(address), .acc_en(acc_en), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    int tests = 0, errors = 0, cyc = 0;
    int start = -1, ae_cnt = 0, e2e_base = 0;
    bit fresh = 1, e2e = 0;
    int acc_q[$], dv_q[$];

    logic [63:0][15:0] sreg;
    logic [63:0][7:0] coef;
    logic [23:0] prod;
    logic [31:0] acc;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int qat(int q[$], int i);
        return q.size() > i ? q[i] : -9999;
    endfunction

    always @(posedge clk) cyc++;

    // Datapath: shift register, coefficient ROM, one product stage and accumulator.
    always @(posedge clk or negedge rst)
        if (!rst) begin
            sreg <= '0;
            prod <= '0;
            acc  <= '0;
        end else begin
            if (shift) sreg <= {sreg[62:0], din};
            prod <= flush ? 24'd0 : 24'(sreg[address]) * 24'(coef[address]);
            acc  <= flush ? 32'd0 : acc_en ? acc + 32'(prod) : acc;
        end

    // Reference: outputs are a pure function of the cycle offset since the last accept.
    always @(negedge clk) begin
        int n, e_rdy, e_addr, e_acc, e_dv, e_sh, idx;
        if (!rst) begin
            chk("rst_address", int'(address), 0);
            chk("rst_acc_en", int'(acc_en), 0);
            chk("rst_dout_valid", int'(dout_valid), 0);
            chk("rst_shift", int'(shift), 0);
            chk("rst_flush", int'(flush), 0);
            start = -1;
            fresh = 1;
        end else begin
            n = start < 0 ? 1000 : cyc - start;
            e_rdy = 0; e_addr = 0; e_acc = 0; e_dv = 0; e_sh = 0;
            if (fresh) fresh = 0;
            else if (n >= 68) begin
                e_rdy = 1;
                e_sh = int'(din_valid);
                if (din_valid) start = cyc;
            end else begin
                e_addr = (n >= 1 && n <= 64) ? n - 1 : 0;
                e_acc = int'(n >= 1 && n <= 65);
                e_dv = int'(n == 67);
            end
            chk("ready", int'(ready), e_rdy);
            chk("address", int'(address), e_addr);
            chk("acc_en", int'(acc_en), e_acc);
            chk("dout_valid", int'(dout_valid), e_dv);
            chk("shift", int'(shift), e_sh);
            chk("flush", int'(flush), e_sh);
        end
        if (dout_valid && e2e) begin
            idx = dv_q.size() - e2e_base;
            if (idx < 64) chk("e2e_dout", int'(acc), int'(coef[idx]));
        end
        if (shift) acc_q.push_back(cyc);
        if (dout_valid) dv_q.push_back(cyc);
        if (acc_en) ae_cnt++;
    end

    initial begin
        int a, b, e;
        for (int i = 0; i < 64; i++) coef[i] = 8'($urandom_range(1, 255));
        repeat (3) @(posedge clk);
        #1 rst = 1;
        tick;

        // single sample
        a = acc_q.size(); b = dv_q.size(); e = ae_cnt;
        din_valid = 1; tick; din_valid = 0;
        repeat (75) tick;
        chk("single_accepts", acc_q.size() - a, 1);
        chk("single_dv_count", dv_q.size() - b, 1);
        chk("single_dv_latency", qat(dv_q, b) - qat(acc_q, a), 67);
        chk("single_acc_en_cycles", ae_cnt - e, 65);

        // busy input ignored at offset 10
        a = acc_q.size(); b = dv_q.size();
        din_valid = 1; tick; din_valid = 0;
        repeat (9) tick;
        din_valid = 1; tick; din_valid = 0;
        repeat (70) tick;
        chk("busy_accepts", acc_q.size() - a, 1);
        chk("busy_dv_latency", qat(dv_q, b) - qat(acc_q, a), 67);

        // back-to-back with din_valid held
        a = acc_q.size(); b = dv_q.size();
        din_valid = 1; repeat (137) tick; din_valid = 0;
        repeat (75) tick;
        chk("b2b_accepts", acc_q.size() - a, 3);
        chk("b2b_accept1", qat(acc_q, a + 1) - qat(acc_q, a), 68);
        chk("b2b_accept2", qat(acc_q, a + 2) - qat(acc_q, a), 136);
        chk("b2b_dv_count", dv_q.size() - b, 3);
        chk("b2b_dv0", qat(dv_q, b) - qat(acc_q, a), 67);
        chk("b2b_dv1", qat(dv_q, b + 1) - qat(acc_q, a), 135);
        chk("b2b_dv2", qat(dv_q, b + 2) - qat(acc_q, a), 203);

        // reset mid-CALC at offset 30
        b = dv_q.size();
        din_valid = 1; tick; din_valid = 0;
        repeat (29) tick;
        rst = 0;
        #1;
        chk("rst_mid_address", int'(address), 0);
        chk("rst_mid_acc_en", int'(acc_en), 0);
        chk("rst_mid_ready", int'(ready), 0);
        repeat (2) tick;
        rst = 1;
        tick;
        chk("rst_mid_no_dv", dv_q.size() - b, 0);
        a = acc_q.size();
        din_valid = 1; tick; din_valid = 0;
        repeat (75) tick;
        chk("rst_recover_dv", dv_q.size() - b, 1);
        chk("rst_recover_latency", qat(dv_q, b) - qat(acc_q, a), 67);

        // end-to-end impulse through the datapath
        rst = 0; tick; rst = 1; tick;
        e2e_base = dv_q.size();
        e2e = 1;
        for (int s = 0; s < 5; s++) begin
            din = s == 0 ? 16'h0001 : 16'h0000;
            din_valid = 1; tick; din_valid = 0;
            repeat (70) tick;
        end
        e2e = 0;
        chk("e2e_samples", dv_q.size() - e2e_base, 5);

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            din_valid = $urandom_range(0, 2) == 0;
            din = 16'($urandom);
            rst = $urandom_range(0, 799) != 0;
            tick;
        end
        rst = 1; din_valid = 0;
        repeat (3) tick;

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/fir_controller.md
FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 SHALL have parameter TapCount, default 64: number of filter taps swept per sample.
REQ-002 SHALL have parameter AddrWidth, default 6: tap address width, equal to clog2(TapCount).
REQ-003 SHALL have parameter PipeDepth, default 2: drain cycles after the last tap before the result is final.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port din_valid  input  1: upstream presents a new sample on the datapath din.
REQ-007 SHALL have port ready  output  1: controller can accept a sample this cycle.
REQ-008 SHALL have port shift  output  1: datapath input shift-register load strobe.
REQ-009 SHALL have port flush  output  1: datapath pipeline/accumulator clear strobe.
REQ-010 SHALL have port address  output  AddrWidth: tap index to shift-register read and coefficient ROM.
REQ-011 SHALL have port acc_en  output  1: accumulation window; high while valid products enter the accumulator.
REQ-012 SHALL have port dout_valid  output  1: one-cycle strobe; datapath dout holds the finished sum.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DRAIN, DONE.
- IDLE: ready=1, address=0; if din_valid=1, assert shift=1 and flush=1 combinationally in that cycle and go to CALC; otherwise stay.
- CALC: address counts 0..TapCount-1, one step per cycle, starting at 0; at TapCount-1, go to DRAIN.
- DRAIN: address held at 0; counts PipeDepth cycles, then goes to DONE.
- DONE: dout_valid=1 for exactly one cycle, then goes to IDLE.
REQ-014 SHALL hold shift and flush low in every cycle other than an IDLE accept cycle.
REQ-015 SHALL drive acc_en=1 during all CALC cycles and the first PipeDepth-1 DRAIN cycles; 0 otherwise. With defaults: 65 cycles.
REQ-016 SHALL drive ready=1 only in IDLE; din_valid in CALC/DRAIN/DONE SHALL be ignored, with no shift and no state change.
REQ-017 SHALL have fixed latency with defaults: accept at cycle 0, CALC cycles 1-64, DRAIN cycles 65-66, dout_valid at cycle 67, ready again at cycle 68.
REQ-018 SHALL give a sample period of TapCount+PipeDepth+2 cycles (68 with defaults) when din_valid is held high continuously.
REQ-019 SHALL wrap the address counter with modulo AddrWidth arithmetic; it SHALL never exceed TapCount-1.
REQ-020 SHALL register all outputs except shift and flush; shift and flush SHALL be decoded from state and din_valid.

Reset
REQ-021 SHALL, when rst=0 at any time including mid-CALC or mid-DRAIN, enter IDLE asynchronously and clear address and the drain counter to 0.
REQ-022 SHALL hold dout_valid=0, acc_en=0, shift=0 and flush=0 while rst=0, with ready=1 from the first rising clk edge after rst deasserts.
REQ-023 SHALL NOT issue a dout_valid for a sample aborted by reset.

Structure
REQ-024 SHALL place the state enum (fir_state_t) and the default TapCount, AddrWidth and PipeDepth constants in shared package fir_pkg.
REQ-025 SHALL use one sub-module, tap_counter: a loadable up-counter with clear, enable and terminal-count output, instantiated for the address counter and the drain counter.

Verification
REQ-026 SHALL cover single sample: one din_valid pulse at cycle 0 -> shift and flush high at cycle 0, address 0..63 over cycles 1-64, dout_valid only at cycle 67.
REQ-027 SHALL cover back-to-back samples: din_valid held high for 3 samples -> accepts at cycles 0, 68 and 136, and exactly 3 dout_valid pulses at cycles 67, 135 and 203.
REQ-028 SHALL cover busy input: din_valid pulsed at cycle 10 after an accept at cycle 0 -> no shift, ready=0, timing unchanged.
REQ-029 SHALL cover reset mid-operation: rst=0 at cycle 30 -> address=0 and outputs low immediately; no dout_valid; a new accept works normally after release.
REQ-030 SHALL cover end-to-end: fir_controller plus datapath, impulse sample 16'h0001 then zeros -> dout equals coeffs[k] at the dout_valid of sample k.
